instruction_fetch: RTL

//   IF stage of the pipelined LEGv8 CPU and the producer of the 96-bit IF/ID buffer

---
 rtl/instruction_fetch.sv | 102 ++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module  : instruction_fetch
// Brief   : LEGv8 IF stage: PC, word-addressed imem, and the IF/ID buffer.
// Revision: 1.0
// ============================================================================
module instruction_fetch #(
    parameter int unsigned IMEM_DEPTH = 64,
    parameter logic [63:0] PC_RESET   = 64'h0,
    parameter logic [31:0] NOP_INSTR  = 32'hD503201F
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          PCSrc,
    input  logic [63:0]                   BranchAddress,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    output logic [95:0]                   outBuf,
    output logic                          out_valid,
    output logic                          imem_fault
);

    localparam int AW = $clog2(IMEM_DEPTH);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_BUBBLE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [95:0] outbuf_q, outbuf_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;

    logic [31:0] mem [IMEM_DEPTH];
    logic        w_in_range;
    logic [31:0] w_fetch_word;

    // Range test uses the full word index so very large PCs never alias into the array.
    assign w_in_range   = (pc_q[63:2] < 62'(IMEM_DEPTH));
    assign w_fetch_word = w_in_range ? mem[pc_q[AW+1:2]] : NOP_INSTR;

    always_ff @(posedge clk) begin
        if (imem_we) begin
            mem[imem_waddr] <= imem_wdata;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        outbuf_d = outbuf_q;
        valid_d  = valid_q;
        fault_d  = fault_q;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            default: begin
                if (PCSrc) begin
                    pc_d     = {BranchAddress[63:2], 2'b00};
                    outbuf_d = {pc_q, NOP_INSTR};
                    valid_d  = 1'b0;
                    fault_d  = fault_q | (BranchAddress[1:0] != 2'b00);
                    state_d  = S_BUBBLE;
                end else if (!stall) begin
                    pc_d     = pc_q + 64'd4;
                    outbuf_d = {pc_q, w_fetch_word};
                    valid_d  = 1'b1;
                    fault_d  = fault_q | ~w_in_range;
                    state_d  = S_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_BOOT;
            pc_q     <= PC_RESET;
            outbuf_q <= {PC_RESET, NOP_INSTR};
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            outbuf_q <= outbuf_d;
            valid_q  <= valid_d;
            fault_q  <= fault_d;
        end
    end

    assign outBuf     = outbuf_q;
    assign out_valid  = valid_q;
    assign imem_fault = fault_q;

endmodule
`default_nettype wire
